viterbi_decoder: RTL
====================

VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 Parameter FRAME_BITS, default 8, SHALL set the number of information bits per frame; each frame SHALL carry N = FRAME_BITS+2 symbol pairs, the last 2 being zero tail.
REQ-002 Parameter MW, default 6, SHALL set the path-metric width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL qualify in_sym.
REQ-006 in_sym  input  2  SHALL carry one hard-decision pair: [1] = G0 bit, [0] = G1 bit.
REQ-007 in_ready  output  1  SHALL be high when a symbol pair can be accepted.
REQ-008 out_valid  output  1  SHALL pulse high for one cycle when a decoded frame is presented.
REQ-009 out_data  output  FRAME_BITS  SHALL hold the decoded bits; the first bit of the frame SHALL be in the MSB.
REQ-010 out_metric  output  MW  SHALL hold the final path metric of state 0, which equals the Hamming distance of the chosen path.

Function
REQ-011 The code SHALL be rate 1/2 with K=3, G0=111 and G1=101.
- G0 bit = x_k^x_k-1^x_k-2.
- G1 bit = x_k^x_k-2.
- Trellis state = {x_k-1, x_k-2}.
- Every frame SHALL start and end in state 0.
REQ-012 The FSM SHALL have three states: ACS, TRACE and OUT.
- ACS -> TRACE after the N-th accepted pair.
- TRACE -> OUT after N traceback cycles.
- OUT -> ACS after one cycle.
REQ-013 A pair SHALL be accepted when in_valid && in_ready; in_ready SHALL equal (state == ACS).
REQ-014 In ACS, each accepted pair SHALL perform one add-compare-select step on all 4 states in the same cycle.
- Branch metric = Hamming distance (0..2) between in_sym and the expected pair.
REQ-015 At the start of a frame, the state-0 metric SHALL be 0 and the state-1..3 metrics SHALL be 2^(MW-1).
REQ-016 Metric adds SHALL saturate at 2^MW-1; no wrap-around.
REQ-017 On equal candidate metrics, the predecessor with x_k-2 = 0 SHALL be selected.
REQ-018 Decision bits (4 per step) SHALL be stored in an N-entry survivor memory indexed by step counter 0..N-1.
REQ-019 TRACE SHALL start in state 0 at step N-1 and walk back one step per cycle.
- Decoded bit for step k = MSB of the state after step k.
- Bits for tail steps N-2 and N-1 SHALL be discarded.
REQ-020 In OUT, out_valid SHALL be 1 and out_data and out_metric SHALL be valid; both SHALL hold their values until the next OUT.
REQ-021 Latency from acceptance of the N-th pair to out_valid SHALL be exactly N+1 cycles.
REQ-022 in_valid during TRACE or OUT SHALL be ignored; no pair is consumed.
REQ-023 Metrics SHALL re-initialise per REQ-015 in the OUT cycle, so frames can run back-to-back.

Reset
REQ-024 rst SHALL immediately force the following:
- FSM state = ACS, step counter = 0, metrics per REQ-015.
- out_valid = 0, out_data = 0, out_metric = 0.
- in_ready = 1 once rst deasserts.
REQ-025 rst asserted mid-frame (ACS or TRACE) SHALL discard the partial frame with no out_valid.
REQ-026 Survivor memory contents need no reset.

Structure
REQ-027 Package conv_pkg SHALL hold K, G0, G1, NUM_STATES=4 and the FSM state typedef; the companion convolutional encoder SHALL reuse it.
REQ-028 One sub-module, viterbi_acs (two candidate metrics plus branch metrics in; new metric and decision bit out), SHALL be instantiated 4 times.

Verification
REQ-029 All-zero frame (ten pairs of 00) -> out_data=8'h00, out_metric=0, out_valid 11 cycles after the 10th pair.
REQ-030 Pairs 11,10,11,00,00,00,00,00,00,00 -> out_data=8'h80, out_metric=0.
REQ-031 Same frame with the 2nd pair corrupted to 00 -> out_data=8'h80, out_metric=1.
REQ-032 in_valid held high through TRACE/OUT with two frames streamed -> in_ready=0 during TRACE/OUT, no pairs lost, both frames decode correctly.
REQ-033 rst pulsed after 5 pairs, then a clean 8'h80 frame -> no out_valid for the aborted frame, next frame gives 8'h80 and metric 0.
REQ-034 Random 8-bit data through a reference encoder with 0 or 1 injected bit errors (1000 frames) -> out_data matches the data, out_metric equals the injected error count.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the K=3, rate-1/2 (G0=111, G1=101) convolutional code.
// Used by the Viterbi decoder and the companion encoder.
package conv_pkg;

  localparam int K          = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int NUM_STATES = 4;

  typedef enum logic [1:0] {
    ST_ACS,
    ST_TRACE,
    ST_OUT
  } state_t;

  // Encoder output pair {G0 bit, G1 bit} for input bit b leaving state s = {x_k-1, x_k-2}
  function automatic logic [1:0] conv_out(input logic b, input logic [1:0] s);
    logic [K-1:0] sr;
    sr = {b, s};
    return {^(sr & G0), ^(sr & G1)};
  endfunction

  // Hamming distance between two 2-bit pairs (0..2)
  function automatic logic [1:0] ham2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: two saturating candidate metrics,
// the smaller survives; ties go to predecessor 0 (x_k-2 = 0).
module viterbi_acs #(
  parameter int MW = 6
) (
  input  logic [MW-1:0] metric0,
  input  logic [MW-1:0] metric1,
  input  logic [1:0]    bm0,
  input  logic [1:0]    bm1,
  output logic [MW-1:0] metric_new,
  output logic          dec
);

  function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] m, input logic [1:0] bm);
    logic [MW:0] sum;
    sum = {1'b0, m} + (MW+1)'(bm);
    return sum[MW] ? {MW{1'b1}} : sum[MW-1:0];
  endfunction

  logic [MW-1:0] cand0;
  logic [MW-1:0] cand1;

  assign cand0      = sat_add(metric0, bm0);
  assign cand1      = sat_add(metric1, bm1);
  assign dec        = (cand1 < cand0);
  assign metric_new = dec ? cand1 : cand0;

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for terminated frames: one ACS step per accepted
// pair, then a one-step-per-cycle traceback from state 0, then a one-cycle output.
module viterbi_decoder
  import conv_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter int MW         = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            in_sym,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [FRAME_BITS-1:0] out_data,
  output logic [MW-1:0]         out_metric
);

  localparam int N  = FRAME_BITS + 2;
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST_STEP   = SW'(N - 1);
  localparam logic [MW-1:0] METRIC_INIT = {1'b1, {(MW-1){1'b0}}};

  state_t                  state_reg;
  logic [SW-1:0]           step_reg;
  logic [MW-1:0]           metric_reg  [NUM_STATES];
  logic [MW-1:0]           metric_next [NUM_STATES];
  logic [NUM_STATES-1:0]   dec_vec;
  logic                    accept;

  logic [NUM_STATES-1:0]   surv_mem [N];
  logic [NUM_STATES-1:0]   surv_rd_reg;
  logic [NUM_STATES-1:0]   last_dec_reg;
  logic [SW-1:0]           rd_addr;
  logic [NUM_STATES-1:0]   dec_sel;

  logic [1:0]              tb_state_reg;
  logic [1:0]              tb_state_next;
  logic [FRAME_BITS-1:0]   tb_bits_reg;
  logic [FRAME_BITS-1:0]   tb_bits_next;

  logic                    out_valid_reg;
  logic [FRAME_BITS-1:0]   out_data_reg;
  logic [MW-1:0]           out_metric_reg;

  assign in_ready   = (state_reg == ST_ACS);
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_metric = out_metric_reg;

  // Next state gi = {b, a} is reached from {a,0} and {a,1} on input bit b
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_acs
      localparam logic       IN_BIT = 1'(gi / 2);
      localparam logic [1:0] PRED0  = 2'((gi % 2) * 2);
      localparam logic [1:0] PRED1  = 2'((gi % 2) * 2 + 1);
      logic [1:0] bm0;
      logic [1:0] bm1;

      assign bm0 = ham2(in_sym, conv_out(IN_BIT, PRED0));
      assign bm1 = ham2(in_sym, conv_out(IN_BIT, PRED1));

      viterbi_acs #(.MW(MW)) u_acs (
        .metric0    (metric_reg[PRED0]),
        .metric1    (metric_reg[PRED1]),
        .bm0        (bm0),
        .bm1        (bm1),
        .metric_new (metric_next[gi]),
        .dec        (dec_vec[gi])
      );
    end
  endgenerate

  // Survivor RAM reads one step ahead of the traceback; the newest step is
  // not yet readable when traceback starts, so it comes from last_dec_reg.
  assign rd_addr = (step_reg == '0) ? '0 : step_reg - SW'(1);

  always_ff @(posedge clk) begin
    if (accept) begin
      surv_mem[step_reg] <= dec_vec;
      last_dec_reg       <= dec_vec;
    end
    surv_rd_reg <= surv_mem[rd_addr];
  end

  always_comb begin
    dec_sel       = (step_reg == LAST_STEP) ? last_dec_reg : surv_rd_reg;
    tb_state_next = {tb_state_reg[0], dec_sel[tb_state_reg]};
    tb_bits_next  = tb_bits_reg;
    // Tail steps carry no information; earlier steps shift in at the MSB
    if (int'(step_reg) < FRAME_BITS)
      tb_bits_next = {tb_state_reg[1], tb_bits_reg[FRAME_BITS-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_ACS;
      step_reg       <= '0;
      tb_state_reg   <= '0;
      tb_bits_reg    <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_metric_reg <= '0;
      for (int i = 0; i < NUM_STATES; i++)
        metric_reg[i] <= (i == 0) ? '0 : METRIC_INIT;
    end else begin
      case (state_reg)
        ST_ACS: begin
          out_valid_reg <= 1'b0;
          if (accept) begin
            for (int i = 0; i < NUM_STATES; i++)
              metric_reg[i] <= metric_next[i];
            if (step_reg == LAST_STEP) begin
              state_reg    <= ST_TRACE;
              tb_state_reg <= '0;
            end else begin
              step_reg <= step_reg + SW'(1);
            end
          end
        end
        ST_TRACE: begin
          tb_state_reg <= tb_state_next;
          tb_bits_reg  <= tb_bits_next;
          if (step_reg == '0) begin
            state_reg      <= ST_OUT;
            out_valid_reg  <= 1'b1;
            out_data_reg   <= tb_bits_next;
            out_metric_reg <= metric_reg[0];
          end else begin
            step_reg <= step_reg - SW'(1);
          end
        end
        ST_OUT: begin
          out_valid_reg <= 1'b0;
          state_reg     <= ST_ACS;
          step_reg      <= '0;
          for (int i = 0; i < NUM_STATES; i++)
            metric_reg[i] <= (i == 0) ? '0 : METRIC_INIT;
        end
        default: begin
          state_reg <= ST_ACS;
          step_reg  <= '0;
        end
      endcase
    end
  end

endmodule
